mips_ex_stage: RTL and testbench
================================

// Module: mips_ex_stage
// PURPOSE
//  Execute-stage slice of the single-issue MIPS datapath: decodes the opcode into main control
//  signals, selects ALU operand B (register vs extended immediate), runs the 32-bit ALU and
//  registers all results for the memory/write-back logic. Sits between register-file read and
//  data memory; one instruction per cycle, no stalls.
// PARAMETERS
//  XLEN  32  datapath width (only 32 supported)
// PORTS
//  clk          in   1     rising-edge clock, single clock domain
//  reset        in   1     synchronous, active-high; clears every output register
//  in_valid     in   1     instruction/operands below are valid this cycle
//  instruction  in   32    raw instruction word
//  read_data1   in   32    rs operand from register file
//  read_data2   in   32    rt operand from register file
//  out_valid    out  1     registered in_valid
//  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, sign_zero
//               out  1 ea  registered main-control signals
//  alu_op       out  2     registered ALUOp
//  write_reg    out  5     registered destination: rd [15:11] if reg_dst else rt [20:16]
//  store_data   out  32    registered read_data2 (for sw)
//  alu_result   out  32    registered ALU result
//  zero         out  1     registered (alu_result == 0)
//  overflow     out  1     registered signed overflow (add/sub only, else 0)
// BEHAVIOUR
//  - Latency 1: inputs sampled at rising clk, outputs valid after that edge; all combinational
//    decode/ALU in between. No handshake/back-pressure; in_valid=0 forces all control outputs
//    (reg_write, mem_*, branch, jump) to 0 in the registered stage; data outputs still update.
//  - reset=1 at an edge: every output register <= 0 (out_valid=0), regardless of in_valid.
//  - Main control by opcode [31:26] (RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,Jump,SignZero):
//    000000 R-type 1,0,0,1,0,0,0,10,0,0 | 100011 lw 0,1,1,1,1,0,0,00,0,0
//    101011 sw 0,1,0,0,0,1,0,00,0,0    | 000100 beq 0,0,0,0,0,0,1,01,0,0
//    001000 addi 0,1,0,1,0,0,0,00,0,0  | 001101 ori 0,1,0,1,0,0,0,11,0,1
//    000010 j all 0 except jump=1      | any other opcode: all signals 0 (NOP)
//  - Immediate: sign_zero=0 -> sign-extend [15:0]; sign_zero=1 -> zero-extend.
//  - Operand mux: B = alu_src ? ext_imm : read_data2; A = read_data1 always.
//  - ALU control (4b): ALUOp 00->ADD 0010; 01->SUB 0110; 11->OR 0001; 10-> by funct [5:0]:
//    100000 ADD, 100010 SUB, 100100 AND 0000, 100101 OR 0001, 101010 SLT 0111, 100111 NOR 1100,
//    other funct -> ADD.
//  - ALU: modulo-2^32 add/sub; SLT signed compare, result 1 or 0; zero = result==0 for every op;
//    overflow = signed overflow for ADD/SUB (operand signs equal and result sign differs, with
//    B inverted for SUB), 0 for logic/SLT. Unknown ALU code -> result 0.
// STRUCTURE
//  - Shared package mips_pkg: opcode constants, funct constants, ALUOp encodings, 4-bit ALU
//    control codes, struct for main-control bundle.
//  - One sub-module: mips_alu32 (purely combinational: a, b, ctrl -> result, zero, overflow).
//  - Control decode, ALU-control decode, extender, operand mux and output register in top.
// TESTING
//  - R add: rs=2,rt=3 (data 2,3), funct 100000 -> next cycle alu_result=5, reg_write=1, write_reg=rd, zero=0.
//  - beq equal: data1=data2=7 -> alu_result=0, zero=1, branch=1, reg_write=0.
//  - lw imm=-4 (0xFFFC), data1=20 -> alu_result=16, mem_read=1, mem_to_reg=1, write_reg=rt;
//    ori imm=0xFFFC, data1=0 -> alu_result=0x0000FFFC, sign_zero=1.
//  - Overflow: add 0x7FFFFFFF+1 -> 0x80000000, overflow=1; slt -1 vs 1 -> 1; nor 0,0 -> 0xFFFFFFFF.
//  - Reset mid-stream: assert reset with valid sw in flight -> all outputs 0 next edge, mem_write=0.
//  - Undefined opcode 111111 / in_valid=0 -> all control outputs 0, out_valid follows in_valid.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared opcode/funct constants, ALU encodings and control bundle
//            for the MIPS execute stage.
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       sign_zero;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/mips_alu32.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu32
// Brief    : Combinational 32-bit ALU (add/sub/and/or/slt/nor) with zero and
//            signed-overflow flags.
// Revision : 1.0  initial release
// ============================================================================
module mips_alu32
    import mips_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_ctrl,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_overflow
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_result;
    logic        w_overflow;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (i_ctrl)
            ALU_ADD: begin
                w_result   = w_sum;
                w_overflow = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            ALU_SUB: begin
                // Subtraction overflows when operand signs differ (B is inverted)
                w_result   = w_diff;
                w_overflow = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            end
            ALU_AND: w_result = i_a & i_b;
            ALU_OR:  w_result = i_a | i_b;
            ALU_NOR: w_result = ~(i_a | i_b);
            ALU_SLT: w_result = {31'b0, ($signed(i_a) < $signed(i_b))};
            default: w_result = '0;
        endcase
    end

    assign o_result   = w_result;
    assign o_zero     = (w_result == 32'd0);
    assign o_overflow = w_overflow;

endmodule
`default_nettype wire

// File: rtl/mips_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : mips_ex_stage
// Brief    : Execute-stage slice: main/ALU control decode, immediate extend,
//            operand select, 32-bit ALU and one output register stage.
// Revision : 1.0  initial release
// ============================================================================
module mips_ex_stage
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    output logic            out_valid,
    output logic            reg_dst,
    output logic            alu_src,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic            sign_zero,
    output logic [1:0]      alu_op,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            overflow
);

    logic [5:0]      w_opcode;
    logic [5:0]      w_funct;
    ctrl_t           w_ctrl;
    logic [3:0]      w_alu_ctrl;
    logic [XLEN-1:0] w_ext_imm;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu_result;
    logic            w_zero;
    logic            w_overflow;
    logic [4:0]      w_write_reg;
    logic            w_unused;

    assign w_opcode = instruction[31:26];
    assign w_funct  = instruction[5:0];
    assign w_unused = ^{instruction[25:21], instruction[10:6]};

    always_comb begin
        w_ctrl = CTRL_NOP;
        case (w_opcode)
            OP_RTYPE: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_ORI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_OR;
                w_ctrl.sign_zero = 1'b1;
            end
            OP_J:    w_ctrl.jump = 1'b1;
            default: w_ctrl = CTRL_NOP;
        endcase
    end

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (w_ctrl.alu_op)
            ALUOP_ADD: w_alu_ctrl = ALU_ADD;
            ALUOP_SUB: w_alu_ctrl = ALU_SUB;
            ALUOP_OR:  w_alu_ctrl = ALU_OR;
            default: begin
                case (w_funct)
                    FUNCT_SUB: w_alu_ctrl = ALU_SUB;
                    FUNCT_AND: w_alu_ctrl = ALU_AND;
                    FUNCT_OR:  w_alu_ctrl = ALU_OR;
                    FUNCT_SLT: w_alu_ctrl = ALU_SLT;
                    FUNCT_NOR: w_alu_ctrl = ALU_NOR;
                    default:   w_alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

    // sign_zero selects zero-extension (logical immediates such as ori)
    assign w_ext_imm = w_ctrl.sign_zero ? {{(XLEN-16){1'b0}}, instruction[15:0]}
                                        : {{(XLEN-16){instruction[15]}}, instruction[15:0]};
    assign w_op_b      = w_ctrl.alu_src ? w_ext_imm : read_data2;
    assign w_write_reg = w_ctrl.reg_dst ? instruction[15:11] : instruction[20:16];

    mips_alu32 u_alu (
        .i_a        (read_data1),
        .i_b        (w_op_b),
        .i_ctrl     (w_alu_ctrl),
        .o_result   (w_alu_result),
        .o_zero     (w_zero),
        .o_overflow (w_overflow)
    );

    logic            r_valid;
    ctrl_t           r_ctrl;
    logic [4:0]      r_write_reg;
    logic [XLEN-1:0] r_store_data;
    logic [XLEN-1:0] r_alu_result;
    logic            r_zero;
    logic            r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_ctrl       <= CTRL_NOP;
            r_write_reg  <= '0;
            r_store_data <= '0;
            r_alu_result <= '0;
            r_zero       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_valid      <= in_valid;
            r_ctrl       <= in_valid ? w_ctrl : CTRL_NOP;
            r_write_reg  <= w_write_reg;
            r_store_data <= read_data2;
            r_alu_result <= w_alu_result;
            r_zero       <= w_zero;
            r_overflow   <= w_overflow;
        end
    end

    assign out_valid  = r_valid;
    assign reg_dst    = r_ctrl.reg_dst;
    assign alu_src    = r_ctrl.alu_src;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign reg_write  = r_ctrl.reg_write;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign branch     = r_ctrl.branch;
    assign jump       = r_ctrl.jump;
    assign sign_zero  = r_ctrl.sign_zero;
    assign alu_op     = r_ctrl.alu_op;
    assign write_reg  = r_write_reg;
    assign store_data = r_store_data;
    assign alu_result = r_alu_result;
    assign zero       = r_zero;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mips_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_ex_stage
// Brief    : Self-checking bench for mips_ex_stage: directed scenarios plus a
//            randomized stream compared against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        out_valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read;
    logic        mem_write, branch, jump, sign_zero, zero, overflow;
    logic [1:0]  alu_op;
    logic [4:0]  write_reg;
    logic [31:0] store_data, alu_result;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        sign_zero;
        logic [1:0]  alu_op;
        logic [4:0]  write_reg;
        logic [31:0] store_data;
        logic [31:0] alu_result;
        logic        zero;
        logic        overflow;
    } out_t;

    out_t obs;
    assign obs = {out_valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                  branch, jump, sign_zero, alu_op, write_reg, store_data, alu_result,
                  zero, overflow};

    always #5 clk = ~clk;

    mips_ex_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .instruction (instruction),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .out_valid   (out_valid),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .jump        (jump),
        .sign_zero   (sign_zero),
        .alu_op      (alu_op),
        .write_reg   (write_reg),
        .store_data  (store_data),
        .alu_result  (alu_result),
        .zero        (zero),
        .overflow    (overflow)
    );

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] funct);
        rtype = {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        itype = {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Reference: instruction semantics computed directly with wide signed arithmetic
    function automatic out_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] rb, input logic v);
        out_t        e;
        logic [31:0] imm, b, r;
        longint      s;
        int          op;
        e  = '0;
        op = 0;
        r  = '0;
        case (ins[31:26])
            6'b000000: begin
                e.reg_dst = 1; e.reg_write = 1; e.alu_op = 2'b10;
                case (ins[5:0])
                    6'h22:   op = 1;
                    6'h24:   op = 2;
                    6'h25:   op = 3;
                    6'h2a:   op = 4;
                    6'h27:   op = 5;
                    default: op = 0;
                endcase
            end
            6'b100011: begin e.alu_src = 1; e.mem_to_reg = 1; e.reg_write = 1; e.mem_read = 1; end
            6'b101011: begin e.alu_src = 1; e.mem_write = 1; end
            6'b000100: begin e.branch = 1; e.alu_op = 2'b01; op = 1; end
            6'b001000: begin e.alu_src = 1; e.reg_write = 1; end
            6'b001101: begin e.alu_src = 1; e.reg_write = 1; e.alu_op = 2'b11; e.sign_zero = 1; op = 3; end
            6'b000010: e.jump = 1;
            default:   ;
        endcase
        imm = e.sign_zero ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        b   = e.alu_src ? imm : rb;
        case (op)
            0: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                e.overflow = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            end
            1: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                e.overflow = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = ~(a | b);
        endcase
        e.alu_result = r;
        e.zero       = (r == 32'd0);
        e.write_reg  = e.reg_dst ? ins[15:11] : ins[20:16];
        e.store_data = rb;
        e.valid      = v;
        if (!v) begin
            e.reg_dst = 0; e.alu_src = 0; e.mem_to_reg = 0; e.reg_write = 0; e.mem_read = 0;
            e.mem_write = 0; e.branch = 0; e.jump = 0; e.sign_zero = 0; e.alu_op = 2'b00;
        end
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                        input logic v);
        @(negedge clk);
        instruction = ins;
        read_data1  = d1;
        read_data2  = d2;
        in_valid    = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(rtype(1, 2, 3, 6'h20), 32'd9, 32'd4, 1'b1);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        reset = 1'b0;
    endtask

    task automatic test_r_add();
        logic [31:0] ins;
        ins = rtype(2, 3, 9, 6'h20);
        step(ins, 32'd2, 32'd3, 1'b1);
        checks++;
        if (alu_result !== 32'd5 || reg_write !== 1'b1 || write_reg !== 5'd9 || zero !== 1'b0) begin
            errors++;
            $display("FAIL r_add: result %h rw %b wr %0d zero %b want 5 1 9 0",
                     alu_result, reg_write, write_reg, zero);
        end
        checks++;
        if (obs !== model(ins, 32'd2, 32'd3, 1'b1)) begin
            errors++;
            $display("FAIL r_add_all: got %h want %h", obs, model(ins, 32'd2, 32'd3, 1'b1));
        end
    endtask

    task automatic test_beq();
        step(itype(6'b000100, 4, 5, 16'h0010), 32'd7, 32'd7, 1'b1);
        checks++;
        if (alu_result !== 32'd0 || zero !== 1'b1 || branch !== 1'b1 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL beq_equal: result %h zero %b br %b rw %b want 0 1 1 0",
                     alu_result, zero, branch, reg_write);
        end
    endtask

    task automatic test_imm();
        step(itype(6'b100011, 1, 12, 16'hFFFC), 32'd20, 32'd99, 1'b1);
        checks++;
        if (alu_result !== 32'd16 || mem_read !== 1'b1 || mem_to_reg !== 1'b1 || write_reg !== 5'd12) begin
            errors++;
            $display("FAIL lw_neg_imm: result %h mr %b m2r %b wr %0d want 16 1 1 12",
                     alu_result, mem_read, mem_to_reg, write_reg);
        end
        step(itype(6'b001101, 1, 13, 16'hFFFC), 32'd0, 32'd5, 1'b1);
        checks++;
        if (alu_result !== 32'h0000FFFC || sign_zero !== 1'b1 || alu_op !== 2'b11) begin
            errors++;
            $display("FAIL ori_zext: result %h sz %b aluop %b want 0000fffc 1 11",
                     alu_result, sign_zero, alu_op);
        end
    endtask

    task automatic test_alu_edges();
        step(rtype(1, 2, 3, 6'h20), 32'h7FFFFFFF, 32'd1, 1'b1);
        checks++;
        if (alu_result !== 32'h80000000 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL add_overflow: result %h ovf %b want 80000000 1", alu_result, overflow);
        end
        step(rtype(1, 2, 3, 6'h22), 32'h80000000, 32'd1, 1'b1);
        checks++;
        if (alu_result !== 32'h7FFFFFFF || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sub_overflow: result %h ovf %b want 7fffffff 1", alu_result, overflow);
        end
        step(rtype(1, 2, 3, 6'h2a), 32'hFFFFFFFF, 32'd1, 1'b1);
        checks++;
        if (alu_result !== 32'd1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL slt_signed: result %h ovf %b want 1 0", alu_result, overflow);
        end
        step(rtype(1, 2, 3, 6'h27), 32'd0, 32'd0, 1'b1);
        checks++;
        if (alu_result !== 32'hFFFFFFFF || zero !== 1'b0) begin
            errors++;
            $display("FAIL nor_zero: result %h zero %b want ffffffff 0", alu_result, zero);
        end
        step(rtype(1, 2, 3, 6'h24), 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1);
        checks++;
        if (alu_result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL and_zero: result %h zero %b want 0 1", alu_result, zero);
        end
    endtask

    task automatic test_reset_midstream();
        step(itype(6'b101011, 2, 3, 16'h0008), 32'd100, 32'hDEADBEEF, 1'b1);
        checks++;
        if (mem_write !== 1'b1 || store_data !== 32'hDEADBEEF || alu_result !== 32'd108) begin
            errors++;
            $display("FAIL sw_before_reset: mw %b sd %h result %h want 1 deadbeef 108",
                     mem_write, store_data, alu_result);
        end
        reset = 1'b1;
        step(itype(6'b101011, 2, 3, 16'h0008), 32'd100, 32'hDEADBEEF, 1'b1);
        checks++;
        if (obs !== '0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_midstream: got %h want 0", obs);
        end
        reset = 1'b0;
    endtask

    task automatic test_nop_invalid();
        logic [31:0] ins;
        ins = itype(6'b111111, 1, 2, 16'h0004);
        step(ins, 32'd3, 32'd4, 1'b1);
        checks++;
        if (obs !== model(ins, 32'd3, 32'd4, 1'b1) || out_valid !== 1'b1 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL undef_opcode: got %h want %h", obs, model(ins, 32'd3, 32'd4, 1'b1));
        end
        ins = itype(6'b100011, 1, 2, 16'h0004);
        step(ins, 32'd3, 32'd4, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || reg_write !== 1'b0 || mem_read !== 1'b0 || alu_result !== 32'd7) begin
            errors++;
            $display("FAIL invalid_lw: ov %b rw %b mr %b result %h want 0 0 0 7",
                     out_valid, reg_write, mem_read, alu_result);
        end
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 6))
            0:       rnd_data = 32'h0;
            1:       rnd_data = 32'h7FFFFFFF;
            2:       rnd_data = 32'h80000000;
            3:       rnd_data = 32'hFFFFFFFF;
            default: rnd_data = $urandom;
        endcase
    endfunction

    task automatic test_random_back_to_back();
        logic [31:0] ins, d1, d2;
        logic [5:0]  op, fn;
        logic        v;
        out_t        exp;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b001101;
                6: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h2a;
                5: fn = 6'h27;
                default: fn = 6'($urandom);
            endcase
            ins = {op, 20'($urandom), fn};
            d1  = rnd_data();
            d2  = ($urandom_range(0, 3) == 0) ? d1 : rnd_data();
            v   = ($urandom_range(0, 4) != 0);
            exp = model(ins, d1, d2, v);
            step(ins, d1, d2, v);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random[%0d]: ins %h a %h b %h v %b got %h want %h",
                         i, ins, d1, d2, v, obs, exp);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        instruction = '0;
        read_data1  = '0;
        read_data2  = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_r_add();
        test_beq();
        test_imm();
        test_alu_edges();
        test_reset_midstream();
        test_nop_invalid();
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
